apb_cmd_master: RTL and testbench

- Single-clock APB-side consumer of the bridge's command path.
- Pops AXI-originated commands from the read port of the command FIFO (FWFT: data valid whenever not empty).
- Executes one APB4 transfer per command and pushes a response word into the write port of the response FIFO.
- Sits entirely in the APB clock domain, between the CDC FIFOs and the APB slave bus.

---
 rtl/apb_cmd_master.sv | 131 +++++++++++++
 tb/tb_apb_cmd_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB4 master that pops one command from an FWFT command FIFO, runs one transfer and pushes a
// response word. Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without pready.
module apb_cmd_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int unsigned RSP_W  = DATA_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_empty,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_rd_en,
    input  logic              rsp_full,
    output logic              rsp_wr_en,
    output logic [RSP_W-1:0]  rsp_data,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e state_q;

    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic              tmo_hit;

    assign cmd_write = cmd_data[CMD_W-1];
    assign cmd_addr  = cmd_data[CMD_W-2 -: ADDR_W];
    assign cmd_wdata = cmd_data[STRB_W +: DATA_W];
    assign cmd_strb  = cmd_data[STRB_W-1:0];

    // Pop is gated by rst so a command is never consumed while the FSM is held in reset.
    assign cmd_rd_en = (state_q == StIdle) && !cmd_empty && !rst;
    assign rsp_wr_en = (state_q == StResp) && !rsp_full;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TmoW-1:0] tmo_cnt_q;

    // Counts completed ACCESS cycles; hits on the last permitted one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StSetup) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StAccess && !pready && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
        end
    end

    assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            pstrb    <= '0;
            rsp_data <= '0;
            busy     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!cmd_empty) begin
                        state_q <= StSetup;
                        psel    <= 1'b1;
                        busy    <= 1'b1;
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                        pstrb   <= cmd_write ? cmd_strb : '0;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    penable <= 1'b1;
                end
                StAccess: begin
                    if (pready) begin
                        state_q  <= StResp;
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        rsp_data <= {pwrite, pslverr, pwrite ? {DATA_W{1'b0}} : prdata};
                    end else if (tmo_hit) begin
                        state_q  <= StResp;
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        rsp_data <= {pwrite, 1'b1, {DATA_W{1'b0}}};
                    end
                end
                StResp: begin
                    if (!rsp_full) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: FIFO/slave models around the DUT, hand-computed responses.
module tb_apb_cmd_master;

    localparam int unsigned CMD_W  = 69;
    localparam int unsigned RSP_W  = 34;
    localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_empty = 1'b1;
    logic [CMD_W-1:0] cmd_data = '0;
    logic             cmd_rd_en;
    logic             rsp_full = 1'b0;
    logic             rsp_wr_en;
    logic [RSP_W-1:0] rsp_data;
    logic [31:0]      paddr;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [31:0]      pwdata;
    logic [3:0]       pstrb;
    logic [31:0]      prdata = '0;
    logic             pready = 1'b0;
    logic             pslverr = 1'b0;
    logic             busy;

    apb_cmd_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_empty(cmd_empty),
        .cmd_data (cmd_data),
        .cmd_rd_en(cmd_rd_en),
        .rsp_full (rsp_full),
        .rsp_wr_en(rsp_wr_en),
        .rsp_data (rsp_data),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CMD_W-1:0] cmd_q[$];
    logic [RSP_W-1:0] rsp_got[$];
    int               push_cyc[$];
    int popped = 0, rd_pulses = 0, wr_pulses = 0, penable_total = 0, cyc = 0;
    int psel_bad = 0, low_run = 100;

    int          slv_waits = 0, slv_wait_cnt = 0;
    logic        slv_err = 1'b0, slv_fixed = 1'b0, late_ready = 1'b0;
    logic [31:0] slv_rdata = '0;

    logic [RSP_W-1:0] exp_rsp[8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk_cmd(input logic wr, input logic [31:0] addr,
                                                input logic [31:0] wdata, input logic [3:0] strb);
        return {wr, addr, wdata, strb};
    endfunction

    function automatic logic [RSP_W-1:0] rsp_pop();
        if (rsp_got.size() == 0) return 'x;
        return rsp_got.pop_front();
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_psel(input logic lvl, input string tag);
        int n = 0;
        while (psel !== lvl && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(psel), 64'(lvl));
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int n = 0;
        while (wr_pulses < target && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(wr_pulses >= target), 64'd1);
    endtask

    // Pulse/response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (cmd_rd_en) rd_pulses++;
        if (rsp_wr_en) begin
            wr_pulses++;
            rsp_got.push_back(rsp_data);
            push_cyc.push_back(cyc);
        end
        if (penable) penable_total++;
        if (psel && !busy) psel_bad++;
        if (psel) begin
            if (low_run == 1) psel_bad++;
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    // APB slave: reads return addr^RD_KEY unless a fixed value is selected; writes return junk.
    always @(negedge clk) begin
        if (psel && penable) begin
            if (slv_wait_cnt >= slv_waits) begin
                pready  = 1'b1;
                pslverr = slv_err;
                prdata  = pwrite ? 32'hFFFF_FFFF : (slv_fixed ? slv_rdata : (paddr ^ RD_KEY));
            end else begin
                pready  = 1'b0;
                pslverr = 1'b1;
                prdata  = 32'hFFFF_FFFF;
                slv_wait_cnt++;
            end
        end else begin
            pready       = late_ready;
            pslverr      = 1'b0;
            prdata       = '0;
            slv_wait_cnt = 0;
        end
    end

    // FWFT command FIFO model.
    always @(posedge clk) begin
        while (popped < rd_pulses && cmd_q.size() > 0) begin
            void'(cmd_q.pop_front());
            popped++;
        end
        #1;
        cmd_empty = (cmd_q.size() == 0);
        cmd_data  = (cmd_q.size() == 0) ? '0 : cmd_q[0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_wr, base_rd, base_pen, base_idx;
        logic [31:0] a;

        // Reset, with a command already waiting
        cmd_q.push_back(mk_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF));
        repeat (3) tick();
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_pstrb", 64'(pstrb), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_wr_en", 64'(rsp_wr_en), 64'd0);
        check("rst_rd_en_gated", 64'(cmd_rd_en), 64'd0);
        at_pos();
        rst = 1'b0;

        // Write, no wait
        tick();
        check("w_idle_rd_en", 64'(cmd_rd_en), 64'd1);
        check("w_idle_psel", 64'(psel), 64'd0);
        tick();
        check("w_setup_psel", 64'(psel), 64'd1);
        check("w_setup_penable", 64'(penable), 64'd0);
        check("w_setup_paddr", 64'(paddr), 64'h10);
        check("w_setup_pwrite", 64'(pwrite), 64'd1);
        check("w_setup_pstrb", 64'(pstrb), 64'hF);
        tick();
        check("w_access_penable", 64'(penable), 64'd1);
        check("w_access_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
        tick();
        check("w_resp_psel", 64'(psel), 64'd0);
        check("w_resp_wr_en", 64'(rsp_wr_en), 64'd1);
        check("w_resp_data", 64'(rsp_data), 64'h2_0000_0000);
        tick();
        check("w_done_busy", 64'(busy), 64'd0);
        check("w_rd_pulses", 64'(rd_pulses), 64'd1);
        check("w_wr_pulses", 64'(wr_pulses), 64'd1);
        check("w_paddr_hold", 64'(paddr), 64'h10);
        check("w_pwdata_hold", 64'(pwdata), 64'hDEAD_BEEF);
        check("w_rsp", 64'(rsp_pop()), 64'h2_0000_0000);

        // Read, 3 wait states, slave error
        slv_waits = 3;
        slv_fixed = 1'b1;
        slv_rdata = 32'h1234_5678;
        slv_err   = 1'b1;
        base_wr   = wr_pulses;
        base_pen  = penable_total;
        cmd_q.push_back(mk_cmd(1'b0, 32'h0000_0044, 32'hAAAA_5555, 4'hF));
        wait_psel(1'b1, "r_setup_wait");
        check("r_setup_penable", 64'(penable), 64'd0);
        check("r_pstrb_zero", 64'(pstrb), 64'd0);
        check("r_pwrite", 64'(pwrite), 64'd0);
        check("r_paddr", 64'(paddr), 64'h44);
        wait_rsp(base_wr + 1, "r_rsp_wait");
        check("r_penable_cycles", 64'(penable_total - base_pen), 64'd4);
        check("r_rsp", 64'(rsp_pop()), 64'h1_1234_5678);
        slv_waits = 0;
        slv_fixed = 1'b0;
        slv_err   = 1'b0;
        tick();

        // Back-pressure on the response FIFO
        at_pos();
        rsp_full = 1'b1;
        base_wr  = wr_pulses;
        base_rd  = rd_pulses;
        cmd_q.push_back(mk_cmd(1'b0, 32'h0000_0080, 32'h0, 4'h0));
        cmd_q.push_back(mk_cmd(1'b1, 32'h0000_0084, 32'h0BAD_F00D, 4'h3));
        wait_psel(1'b1, "bp_setup_wait");
        wait_psel(1'b0, "bp_resp_wait");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_wr_en%0d", i), 64'(rsp_wr_en), 64'd0);
            check($sformatf("bp_hold_rd_en%0d", i), 64'(cmd_rd_en), 64'd0);
            check($sformatf("bp_hold_busy%0d", i), 64'(busy), 64'd1);
            check($sformatf("bp_hold_data%0d", i), 64'(rsp_data), 64'h0_5A5A_0080);
            if (i < 4) tick();
        end
        check("bp_no_pop", 64'(rd_pulses - base_rd), 64'd1);
        at_pos();
        rsp_full = 1'b0;
        tick();
        check("bp_push_now", 64'(rsp_wr_en), 64'd1);
        check("bp_push_count", 64'(wr_pulses - base_wr), 64'd1);
        tick();
        check("bp_idle_busy", 64'(busy), 64'd0);
        check("bp_next_pop", 64'(cmd_rd_en), 64'd1);
        wait_rsp(base_wr + 2, "bp_second_wait");
        check("bp_rsp0", 64'(rsp_pop()), 64'h0_5A5A_0080);
        check("bp_rsp1", 64'(rsp_pop()), 64'h2_0000_0000);
        tick();

        // Stream of 8 queued commands
        base_wr  = wr_pulses;
        base_idx = push_cyc.size();
        for (int i = 0; i < 8; i++) begin
            a = 32'h0000_1000 + 32'(i * 4);
            cmd_q.push_back(mk_cmd(i[0], a, 32'h1111_1111 * 32'(i), 4'hF));
            exp_rsp[i] = i[0] ? 34'h2_0000_0000 : {2'b00, a ^ RD_KEY};
        end
        wait_rsp(base_wr + 8, "s_rsp_wait");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s_rsp%0d", i), 64'(rsp_pop()), 64'(exp_rsp[i]));
        end
        for (int i = 1; i < 8; i++) begin
            check($sformatf("s_gap%0d", i),
                  64'(push_cyc[base_idx + i] - push_cyc[base_idx + i - 1]), 64'd4);
        end
        tick();

        // Reset during the 2nd wait cycle of ACCESS
        slv_waits = 5;
        base_wr   = wr_pulses;
        cmd_q.push_back(mk_cmd(1'b0, 32'h0000_0300, 32'h0, 4'h0));
        wait_psel(1'b1, "mr_setup_wait");
        tick();
        tick();
        check("mr_in_access", 64'(penable), 64'd1);
        rst = 1'b1;
        #1;
        check("mr_psel", 64'(psel), 64'd0);
        check("mr_penable", 64'(penable), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_rsp_wr_en", 64'(rsp_wr_en), 64'd0);
        at_pos();
        at_pos();
        rst       = 1'b0;
        slv_waits = 0;
        repeat (3) tick();
        check("mr_no_rsp", 64'(wr_pulses - base_wr), 64'd0);
        cmd_q.push_back(mk_cmd(1'b0, 32'h0000_0100, 32'h0, 4'h0));
        wait_rsp(base_wr + 1, "mr_after_wait");
        check("mr_after_rsp", 64'(rsp_pop()), 64'h0_5A5A_0100);
        tick();

`ifdef APB_TIMEOUT_EN
        // ACCESS timeout with a slave that never responds
        slv_waits = 1000;
        base_wr   = wr_pulses;
        base_pen  = penable_total;
        cmd_q.push_back(mk_cmd(1'b1, 32'h0000_0200, 32'hCAFE_0001, 4'hF));
        wait_rsp(base_wr + 1, "to_rsp_wait");
        check("to_access_cycles", 64'(penable_total - base_pen), 64'd4);
        check("to_rsp", 64'(rsp_pop()), 64'h3_0000_0000);
        tick();
        late_ready = 1'b1;
        tick();
        tick();
        late_ready = 1'b0;
        slv_waits  = 0;
        tick();
        check("to_no_second_rsp", 64'(wr_pulses - base_wr), 64'd1);
        check("to_idle_busy", 64'(busy), 64'd0);
`endif

        check("psel_gap_rules", 64'(psel_bad), 64'd0);
        check("rsp_queue_empty", 64'(rsp_got.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
